// File: rtl/riscv_if_prefetch.sv
// riscv_if_prefetch -- instruction-fetch prefetch queue.
//
// Issues fetch requests for if_nxt_pc whenever the parcel queue plus the
// in-flight requests leave room for another response, tags every request
// with its address and misalignment, and queues the in-order responses
// for the IF stage. A flush empties the queue and discards the responses
// of requests that were already in flight.
//
// Optional feature: define RV12_PFQ_BYPASS_EN to let a response that
// arrives while the queue is empty drive the parcel outputs in the same
// cycle. Without the macro every response passes through the queue.

module riscv_if_prefetch #(
    parameter int XLEN        = 32,
    parameter int PARCEL_SIZE = 32,
    parameter int DEPTH       = 4
) (
    input  logic                   clk,
    input  logic                   rst,

    // IF stage side
    input  logic [XLEN-1:0]        if_nxt_pc,
    input  logic                   if_stall,
    input  logic                   if_flush,
    output logic                   if_stall_nxt_pc,
    output logic [PARCEL_SIZE-1:0] if_parcel,
    output logic [XLEN-1:0]        if_parcel_pc,
    output logic                   if_parcel_valid,
    output logic                   if_parcel_misaligned,
    output logic                   if_parcel_page_fault,

    // Memory side
    output logic                   mem_req,
    output logic [XLEN-1:0]        mem_adr,
    input  logic                   mem_gnt,
    input  logic                   mem_ack,
    input  logic [PARCEL_SIZE-1:0] mem_rdata,
    input  logic                   mem_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W+1)'(DEPTH);

    // One queued parcel: fetched data plus the qualifiers the IF stage needs.
    typedef struct packed {
        logic [PARCEL_SIZE-1:0] data;
        logic [XLEN-1:0]        pc;
        logic                   misaligned;
        logic                   page_fault;
    } parcel_t;

    // Tag remembered for each request until its response comes back.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            misaligned;
    } tag_t;

    // Parcel queue
    parcel_t          q_mem [DEPTH];
    logic [PTR_W-1:0] q_rd_ptr;
    logic [PTR_W-1:0] q_wr_ptr;
    logic [CNT_W-1:0] q_count;

    // In-flight tag FIFO and response bookkeeping
    tag_t             tag_mem [DEPTH];
    logic [PTR_W-1:0] tag_rd_ptr;
    logic [PTR_W-1:0] tag_wr_ptr;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] discard;

    logic [CNT_W:0]   in_use;
    logic             issue;
    logic             ack_valid;
    logic             ack_accept;
    logic             q_empty;
    logic             bypass;
    logic             push;
    logic             pop;
    parcel_t          rsp;
    parcel_t          head;
    tag_t             tag_head;

    // ------------------------------------------------------------------
    // Request side
    // ------------------------------------------------------------------
    assign mem_adr = if_nxt_pc;

    // Every slot is either holding a parcel or reserved by a request in
    // flight, so the queue can never be asked to take more than DEPTH.
    assign in_use  = {1'b0, q_count} + {1'b0, outstanding};
    assign mem_req = ~rst & ~if_flush & ~if_stall & (in_use < DEPTH_LIM);
    assign issue   = mem_req & mem_gnt;

    assign if_stall_nxt_pc = ~issue;

    // ------------------------------------------------------------------
    // Response side
    // ------------------------------------------------------------------
    // An ack with nothing in flight is stray (e.g. after a reset) and is ignored.
    assign ack_valid  = ~rst & mem_ack & (outstanding != '0);
    // Acks in the flush cycle and acks owed to pre-flush requests are dropped.
    assign ack_accept = ack_valid & ~if_flush & (discard == '0);

    assign tag_head = tag_mem[tag_rd_ptr];
    assign rsp      = '{data:       mem_rdata,
                        pc:         tag_head.pc,
                        misaligned: tag_head.misaligned,
                        page_fault: mem_err};

    assign q_empty = (q_count == '0);

`ifdef RV12_PFQ_BYPASS_EN
    assign bypass = ack_accept & q_empty;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed response that the IF stage takes right away never enters
    // the queue; if the stage is stalled it is parked in the queue instead.
    assign push = ack_accept & ~(bypass & ~if_stall);
    assign pop  = if_parcel_valid & ~if_stall & ~q_empty;

    // Select what the IF stage sees: the queue head, or the live response.
    // NOTE: head gets its default before the conditional override, so every
    // path through the block assigns it and no latch is inferred.
    always_comb begin
        head = q_mem[q_rd_ptr];
        if (bypass) begin
            head = rsp;
        end
    end

    assign if_parcel_valid      = ~rst & ~if_flush & (~q_empty | bypass);
    assign if_parcel            = head.data;
    assign if_parcel_pc         = head.pc;
    assign if_parcel_misaligned = if_parcel_valid & head.misaligned;
    assign if_parcel_page_fault = if_parcel_valid & head.page_fault;

    // ------------------------------------------------------------------
    // Parcel queue control
    // ------------------------------------------------------------------
    // Queue pointers and occupancy; a flush simply empties the queue.
    // NOTE: state registers use non-blocking assignments so every flop in
    // the block samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst || if_flush) begin
            q_rd_ptr <= '0;
            q_wr_ptr <= '0;
            q_count  <= '0;
        end else begin
            if (push) begin
                q_wr_ptr <= q_wr_ptr + 1'b1;
            end
            if (pop) begin
                q_rd_ptr <= q_rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   q_count <= q_count + 1'b1;
                2'b01:   q_count <= q_count - 1'b1;
                default: q_count <= q_count;
            endcase
        end
    end

    // Parcel storage write.
    // NOTE: the storage array is not reset; the cleared pointers and count
    // already mark every entry empty, and a reset-free array stays plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            q_mem[q_wr_ptr] <= rsp;
        end
    end

    // ------------------------------------------------------------------
    // In-flight tracking
    // ------------------------------------------------------------------
    // Tag FIFO pointers and the outstanding counter. These are not cleared
    // by a flush: the discarded responses still have to retire their tags.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_rd_ptr  <= '0;
            tag_wr_ptr  <= '0;
            outstanding <= '0;
        end else begin
            if (issue) begin
                tag_wr_ptr <= tag_wr_ptr + 1'b1;
            end
            if (ack_valid) begin
                tag_rd_ptr <= tag_rd_ptr + 1'b1;
            end
            case ({issue, ack_valid})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Tag storage write: address and misalignment of each issued request.
    always_ff @(posedge clk) begin
        if (issue) begin
            tag_mem[tag_wr_ptr] <= '{pc: mem_adr, misaligned: |mem_adr[1:0]};
        end
    end

    // Discard counter: on flush, every request still in flight (minus the
    // one retiring this cycle) owes an ack that must not reach the queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            discard <= '0;
        end else if (if_flush) begin
            discard <= outstanding - CNT_W'(ack_valid);
        end else if (ack_valid && (discard != '0)) begin
            discard <= discard - 1'b1;
        end
    end

endmodule

// File: tb/tb_riscv_if_prefetch.sv
// tb_riscv_if_prefetch -- directed self-checking bench for riscv_if_prefetch.
// A small memory model answers granted requests in order; each phase
// drives a hand-built scenario and compares outputs against constants.
// Build with RV12_PFQ_BYPASS_EN defined to exercise the bypass timing.

module tb_riscv_if_prefetch;

    localparam int XLEN  = 32;
    localparam int PS    = 32;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [XLEN-1:0] if_nxt_pc;
    logic            if_stall;
    logic            if_flush;
    logic            if_stall_nxt_pc;
    logic [PS-1:0]   if_parcel;
    logic [XLEN-1:0] if_parcel_pc;
    logic            if_parcel_valid;
    logic            if_parcel_misaligned;
    logic            if_parcel_page_fault;
    logic            mem_req;
    logic [XLEN-1:0] mem_adr;
    logic            mem_gnt;
    logic            mem_ack;
    logic [PS-1:0]   mem_rdata;
    logic            mem_err;

    riscv_if_prefetch #(
        .XLEN        (XLEN),
        .PARCEL_SIZE (PS),
        .DEPTH       (DEPTH)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .if_nxt_pc            (if_nxt_pc),
        .if_stall             (if_stall),
        .if_flush             (if_flush),
        .if_stall_nxt_pc      (if_stall_nxt_pc),
        .if_parcel            (if_parcel),
        .if_parcel_pc         (if_parcel_pc),
        .if_parcel_valid      (if_parcel_valid),
        .if_parcel_misaligned (if_parcel_misaligned),
        .if_parcel_page_fault (if_parcel_page_fault),
        .mem_req              (mem_req),
        .mem_adr              (mem_adr),
        .mem_gnt              (mem_gnt),
        .mem_ack              (mem_ack),
        .mem_rdata            (mem_rdata),
        .mem_err              (mem_err)
    );

    always #5 clk = ~clk;

    int              n_tests = 0;
    int              n_fail  = 0;
    logic [XLEN-1:0] pend[$];          // granted addresses awaiting an ack
    logic [XLEN-1:0] err_adr = '1;     // address whose ack carries mem_err
    logic            pc_load_en = 1'b0;
    logic [XLEN-1:0] pc_load = '0;
    logic [XLEN-1:0] exp_pc;
    logic            req_seen;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [PS-1:0] data_of(input logic [XLEN-1:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Advance one clock. The handshake seen just before the edge is logged,
    // the PC advances on a grant, and the memory model answers the oldest
    // pending request when ack_en is set. Outputs are left settled at +2.
    task automatic tick(input bit stall, input bit flush, input bit ack_en);
        logic            iss;
        logic [XLEN-1:0] a;
        iss = mem_req & mem_gnt;
        if (iss) pend.push_back(mem_adr);
        @(posedge clk);
        #1;
        if (pc_load_en) begin
            if_nxt_pc  = pc_load;
            pc_load_en = 1'b0;
        end else if (iss) begin
            if_nxt_pc = if_nxt_pc + 32'd4;
        end
        if_stall = stall;
        if_flush = flush;
        if (ack_en && pend.size() != 0) begin
            a         = pend.pop_front();
            mem_ack   = 1'b1;
            mem_rdata = data_of(a);
            mem_err   = (a == err_adr);
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = '0;
            mem_err   = 1'b0;
        end
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        if_nxt_pc = 32'h200;
        if_stall  = 1'b0;
        if_flush  = 1'b0;
        mem_gnt   = 1'b1;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        mem_err   = 1'b0;

        // Reset values, with a grant already offered
        repeat (3) @(posedge clk);
        #2;
        check("rst_mem_req",    mem_req, 0);
        check("rst_valid",      if_parcel_valid, 0);
        check("rst_stall_nxt",  if_stall_nxt_pc, 1);
        check("rst_misaligned", if_parcel_misaligned, 0);
        check("rst_page_fault", if_parcel_page_fault, 0);

        // Streaming fetch from 0x200, ack one cycle after each grant;
        // the response for 0x208 carries a bus error
        err_adr = 32'h208;
        rst = 1'b0;
        #1;
        check("stream_req",       mem_req, 1);
        check("stream_stall_nxt", if_stall_nxt_pc, 0);
        tick(0, 0, 1);
`ifndef RV12_PFQ_BYPASS_EN
        check("stream_latency", if_parcel_valid, 0);
        tick(0, 0, 1);
`endif
        for (int i = 0; i < 4; i++) begin
            exp_pc = 32'h200 + 32'(4 * i);
            check("stream_valid", if_parcel_valid, 1);
            check("stream_pc",    if_parcel_pc, exp_pc);
            check("stream_data",  if_parcel, data_of(exp_pc));
            check("stream_pf",    if_parcel_page_fault, exp_pc == 32'h208);
            check("stream_mis",   if_parcel_misaligned, 0);
            tick(0, 0, 1);
        end

        // Withdraw the grant and drain: request stays up, nothing issues
        mem_gnt = 1'b0;
        #1;
        repeat (4) tick(0, 0, 1);
        check("idle_valid",     if_parcel_valid, 0);
        check("idle_req",       mem_req, 1);
        check("idle_stall_nxt", if_stall_nxt_pc, 1);

        // Fill: four grants without acks, then the request must drop
        if_nxt_pc = 32'h300;
        mem_gnt   = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("fill_req", mem_req, 1);
            tick(0, 0, 0);
        end
        check("full_req",       mem_req, 0);
        check("full_stall_nxt", if_stall_nxt_pc, 1);

        // Stall for 10 cycles while the four acks arrive
        req_seen = 1'b0;
        repeat (10) begin
            tick(1, 0, 1);
            if (mem_req) req_seen = 1'b1;
        end
        check("stall_no_req", req_seen, 0);
        check("stall_valid",  if_parcel_valid, 1);
        check("stall_pc",     if_parcel_pc, 32'h300);
        check("stall_data",   if_parcel, data_of(32'h300));

        // Release: the four queued parcels, then the next fetch, in order
        for (int i = 0; i < 5; i++) begin
            tick(0, 0, 1);
            exp_pc = 32'h300 + 32'(4 * i);
            check("resume_valid", if_parcel_valid, 1);
            check("resume_pc",    if_parcel_pc, exp_pc);
        end

        mem_gnt = 1'b0;
        #1;
        repeat (8) tick(0, 0, 1);
        check("drain_valid", if_parcel_valid, 0);

        // Flush with three requests in flight; their acks must be discarded
        if_nxt_pc = 32'h380;
        mem_gnt   = 1'b1;
        #1;
        repeat (2) tick(0, 0, 0);
        pc_load    = 32'h400;
        pc_load_en = 1'b1;
        tick(0, 1, 0);
        check("flush_req",   mem_req, 0);
        check("flush_valid", if_parcel_valid, 0);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 1);
            check("flush_discard", if_parcel_valid, 0);
        end
        tick(0, 0, 1);
`ifndef RV12_PFQ_BYPASS_EN
        check("flush_latency", if_parcel_valid, 0);
        tick(0, 0, 1);
`endif
        check("flush_first_valid", if_parcel_valid, 1);
        check("flush_first_pc",    if_parcel_pc, 32'h400);

        mem_gnt = 1'b0;
        #1;
        repeat (8) tick(0, 0, 1);

        // Flush in the same cycle as the only outstanding ack
        if_nxt_pc = 32'h500;
        mem_gnt   = 1'b1;
        #1;
        tick(0, 0, 0);
        mem_gnt = 1'b0;
        #1;
        tick(0, 1, 1);
        check("flack_valid", if_parcel_valid, 0);
        tick(0, 0, 1);
        check("flack_dropped", if_parcel_valid, 0);
        if_nxt_pc = 32'h600;
        mem_gnt   = 1'b1;
        #1;
        check("flack_req", mem_req, 1);
        tick(0, 0, 1);
        mem_gnt = 1'b0;
        #1;
`ifndef RV12_PFQ_BYPASS_EN
        check("flack_latency", if_parcel_valid, 0);
        tick(0, 0, 1);
`endif
        check("flack_next_valid", if_parcel_valid, 1);
        check("flack_next_pc",    if_parcel_pc, 32'h600);

        repeat (4) tick(0, 0, 1);

        // Misaligned fetch into an empty queue: ack-to-valid latency
        if_nxt_pc = 32'h20A;
        mem_gnt   = 1'b1;
        #1;
        tick(0, 0, 0);
        mem_gnt = 1'b0;
        #1;
        tick(0, 0, 1);
`ifdef RV12_PFQ_BYPASS_EN
        check("mis_bypass_valid", if_parcel_valid, 1);
`else
        check("mis_ack_cycle_valid", if_parcel_valid, 0);
        tick(0, 0, 1);
        check("mis_next_cycle_valid", if_parcel_valid, 1);
`endif
        check("mis_pc",   if_parcel_pc, 32'h20A);
        check("mis_flag", if_parcel_misaligned, 1);
        check("mis_pf",   if_parcel_page_fault, 0);
        check("mis_data", if_parcel, data_of(32'h20A));

        repeat (3) tick(0, 0, 1);

        // Reset with two fetches in flight; their late acks are ignored
        if_nxt_pc = 32'h800;
        mem_gnt   = 1'b1;
        #1;
        repeat (2) tick(0, 0, 0);
        rst = 1'b1;
        #1;
        check("mrst_req",       mem_req, 0);
        check("mrst_stall_nxt", if_stall_nxt_pc, 1);
        tick(0, 0, 0);
        rst     = 1'b0;
        mem_gnt = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 1);
            check("mrst_late_ack", if_parcel_valid, 0);
        end

        // Fetching still works after the abandoned transfer
        if_nxt_pc = 32'h900;
        mem_gnt   = 1'b1;
        #1;
        tick(0, 0, 0);
        mem_gnt = 1'b0;
        #1;
        tick(0, 0, 1);
`ifndef RV12_PFQ_BYPASS_EN
        tick(0, 0, 1);
`endif
        check("post_rst_valid", if_parcel_valid, 1);
        check("post_rst_pc",    if_parcel_pc, 32'h900);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
